// File: rtl/watch_dp.sv
// watch_dp: time-keeping datapath for the watch.
// A prescaler derives a centisecond strobe from clk; a single-cycle carry chain
// ripples msec -> sec -> min -> hour. Six adjust ticks from the control unit
// step sec/min/hour by one with wrap-around and never carry or borrow. An adjust
// on a field wins over that cycle's timebase carry into the field, and it also
// blocks the carry out of that field.

module watch_dp #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int RST_HOUR = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       tick_sec_up,
    input  logic       tick_sec_down,
    input  logic       tick_min_up,
    input  logic       tick_min_down,
    input  logic       tick_hour_up,
    input  logic       tick_hour_down,
    output logic [6:0] msec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       sec_pulse
);

    localparam int              DIV      = CLK_HZ / TICK_HZ;
    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [6:0]      MSEC_MAX = 7'd99;
    localparam logic [5:0]      SEC_MAX  = 6'd59;
    localparam logic [5:0]      MIN_MAX  = 6'd59;
    localparam logic [5:0]      HOUR_MAX = 6'd23;
    localparam logic [4:0]      HOUR_RST = 5'(RST_HOUR);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          cen;
    logic          carry_sec;
    logic          carry_min;
    logic          carry_hour;
    logic          sec_adj;
    logic          min_adj;
    logic          hour_adj;
    logic [6:0]    msec_d;
    logic [5:0]    sec_d;
    logic [5:0]    min_d;
    logic [5:0]    hour_d6;
    logic [4:0]    hour_d;

    // Single-step adjust with wrap; up and down together cancel out.
    function automatic logic [5:0] step_field(
        input logic [5:0] v,
        input logic       up,
        input logic       dn,
        input logic [5:0] max_v
    );
        logic [5:0] r;
        r = v;
        if (up && !dn) begin
            r = (v == max_v) ? 6'd0 : v + 6'd1;
        end else if (dn && !up) begin
            r = (v == 6'd0) ? max_v : v - 6'd1;
        end
        return r;
    endfunction

    // Prescaler next value and the centisecond strobe.
    always_comb begin
        cen   = run && (pre_q == PRE_LAST);
        pre_d = pre_q;
        if (run) begin
            pre_d = cen ? '0 : pre_q + 1'b1;
        end
    end

    // msec advance; carry into sec fires on the 99 -> 0 wrap.
    always_comb begin
        carry_sec = cen && (msec == MSEC_MAX);
        msec_d    = msec;
        if (cen) begin
            msec_d = carry_sec ? 7'd0 : msec + 7'd1;
        end
    end

    // sec field: an adjust overrides the carry in and suppresses the carry out.
    always_comb begin
        sec_adj   = tick_sec_up || tick_sec_down;
        carry_min = 1'b0;
        sec_d     = sec;
        if (sec_adj) begin
            sec_d = step_field(sec, tick_sec_up, tick_sec_down, SEC_MAX);
        end else if (carry_sec) begin
            carry_min = (sec == SEC_MAX);
            sec_d     = (sec == SEC_MAX) ? 6'd0 : sec + 6'd1;
        end
    end

    // min field: same rules as sec.
    always_comb begin
        min_adj    = tick_min_up || tick_min_down;
        carry_hour = 1'b0;
        min_d      = min;
        if (min_adj) begin
            min_d = step_field(min, tick_min_up, tick_min_down, MIN_MAX);
        end else if (carry_min) begin
            carry_hour = (min == MIN_MAX);
            min_d      = (min == MIN_MAX) ? 6'd0 : min + 6'd1;
        end
    end

    // hour field: top of the chain, 23 -> 0 has nowhere further to carry.
    always_comb begin
        hour_adj = tick_hour_up || tick_hour_down;
        hour_d6  = {1'b0, hour};
        if (hour_adj) begin
            hour_d6 = step_field({1'b0, hour}, tick_hour_up, tick_hour_down, HOUR_MAX);
        end else if (carry_hour) begin
            hour_d6 = ({1'b0, hour} == HOUR_MAX) ? 6'd0 : {1'b0, hour} + 6'd1;
        end
        hour_d = hour_d6[4:0];
    end

    // State registers; sec_pulse flags a timebase carry into sec even when an adjust overrode it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q     <= '0;
            msec      <= 7'd0;
            sec       <= 6'd0;
            min       <= 6'd0;
            hour      <= HOUR_RST;
            sec_pulse <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            msec      <= msec_d;
            sec       <= sec_d;
            min       <= min_d;
            hour      <= hour_d;
            sec_pulse <= carry_sec;
        end
    end

endmodule

// File: doc/watch_dp.md
# watch_dp

Time-keeping datapath for the watch. It acts on the six single-cycle adjust ticks issued by the watch control unit, and it keeps its own free-running centisecond/second/minute/hour count from a clock prescaler. Its outputs drive the FND/UART display path. Each adjust tick moves exactly one field by one step, with wrap-around and no carry.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, centisecond rate. Prescaler divide value DIV = CLK_HZ/TICK_HZ; must be ≥ 2.
- RST_HOUR, 12, hour value loaded on reset (0..23).
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- run  input  1  1 = timebase counts; 0 = timebase frozen, adjust still works.
- tick_sec_up  input  1  one-cycle pulse: sec +1.
- tick_sec_down  input  1  one-cycle pulse: sec −1.
- tick_min_up  input  1  one-cycle pulse: min +1.
- tick_min_down  input  1  one-cycle pulse: min −1.
- tick_hour_up  input  1  one-cycle pulse: hour +1.
- tick_hour_down  input  1  one-cycle pulse: hour −1.
- msec  output  7  centiseconds, 0..99.
- sec  output  6  seconds, 0..59.
- min  output  6  minutes, 0..59.
- hour  output  5  hours, 0..23.
- sec_pulse  output  1  one-cycle pulse when sec advances through the timebase. Not asserted on adjust.

## Operation
- **Reset** (rst=0, asynchronous): prescaler=0, msec=0, sec=0, min=0, hour=RST_HOUR, sec_pulse=0.
- **Prescaler**: counts 0..DIV−1 while run=1. It holds its value while run=0.
- **Centisecond advance**: a cen strobe fires in a cycle where run=1 and prescaler=DIV−1. The prescaler returns to 0 in that cycle.
- **Carry chain**, evaluated in the same cycle:
  - On cen, msec increments.
  - msec 99→0 carries to sec.
  - sec 59→0 carries to min.
  - min 59→0 carries to hour.
  - hour 23→0 has no further carry.
- **sec_pulse** is registered. It is 1 in the cycle after any carry into sec, whether or not that carry is later overridden by an adjust.
- **Adjust**, per field F in {sec, min, hour}:
  - up only: F = (F == max) ? 0 : F+1.
  - down only: F = (F == 0) ? max : F−1.
  - max = 59 for sec and min, 23 for hour.
  - up and down together: F holds.
- **Adjust never carries or borrows.** For example, sec up at 59 gives sec=0 and min is unchanged.
- **Priority within a field**: if any adjust tick for F is present, the adjust result is stored and that cycle's timebase carry into F is discarded. Carry out of F is also suppressed.
- **Independence**: ticks for different fields in the same cycle apply independently. msec and the prescaler are never affected by adjust.
- **Tick inputs** are used directly as synchronous enables. They are assumed one-cycle and synchronous to clk. A tick held high for k cycles applies k steps.
- **Reset mid-operation**: all state returns to reset values immediately. The first cen comes DIV cycles after rst deasserts with run=1.

## Timing
- All outputs are registered. An adjust tick sampled at edge N is visible on its field after edge N.
- A cen at edge N updates msec, plus any rippled sec/min/hour, at edge N. The whole carry chain resolves in a single cycle.
- sec_pulse rises after the same edge where sec advances, and stays high for exactly one cycle.
- With run=1 continuously, msec advances every DIV cycles and sec every 100·DIV cycles.
- Freezing run=0 at prescaler value p and resuming continues from p. Phase is preserved.

## Test plan
- **Reset and first count**: CLK_HZ=1000, TICK_HZ=100 (DIV=10), run=1, release rst → after 10 clocks msec=1. After 1000 clocks sec=1, with sec_pulse high for one cycle.
- **Full rollover**: force the state near 23:59:59.99 by adjusting (hour down ×13 from 12 → 23, min down ×1 → 59, sec down ×1 → 59), then let msec reach 99. One cen later → 00:00:00.00.
- **Adjust wrap with no carry**: sec=59, pulse tick_sec_up → sec=0, min unchanged. hour=0, pulse tick_hour_down → hour=23.
- **Adjust/carry collision**: msec=99 and prescaler=DIV−1, with tick_sec_down in the same cycle and sec=10 → sec=9, msec=0, min unchanged, sec_pulse=1 next cycle.
- **Simultaneous up and down**: tick_min_up=tick_min_down=1 with min=30 → min stays 30. A tick_hour_up in the same cycle still applies.
- **run freeze and async reset**: run=0 for 50 cycles → msec/sec constant, and adjusts still apply. Assert rst mid-count between edges → outputs read 00:00:00 with hour=RST_HOUR with no clock edge needed.
